// File: rtl/logic_unit.sv
// logic_unit: pipelined bitwise unit (8 ops on two DATA_WIDTH operands), optional zero/parity flags under `LOGIC_UNIT_STATUS_EN.
// Latency: PIPE_STAGES cycles from input transfer to out_valid_o; one result per cycle while out_ready_i is high.
// Backpressure: elastic valid/ready stages, in_ready_o is combinational from out_ready_i; holds up to PIPE_STAGES entries.
module logic_unit #(
   parameter int DATA_WIDTH  = 8,
   parameter int PIPE_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [2:0]            op_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  zero_o,
   output logic                  parity_o
);

`ifdef LOGIC_UNIT_STATUS_EN
   // Flags ride along with the data as {zero, parity, result}.
   localparam int PAY_W = DATA_WIDTH + 2;
`else
   localparam int PAY_W = DATA_WIDTH;
`endif

   logic [DATA_WIDTH-1:0]  op_res;
   logic [PAY_W-1:0]       in_pay;
   logic [PAY_W-1:0]       stage_dat [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] stage_vld;
   logic [PIPE_STAGES-1:0] stage_rdy;

`ifdef SIMULATION
   if (PIPE_STAGES < 1 || PIPE_STAGES > 4 || DATA_WIDTH < 1) begin : g_param_chk
      $error("logic_unit: illegal parameters PIPE_STAGES=%0d DATA_WIDTH=%0d", PIPE_STAGES, DATA_WIDTH);
   end
`endif

   // Result is formed before stage 0 so every stage only moves data.
   always_comb begin
      op_res = a_i;
      case (op_i)
         3'd0:    op_res = a_i & b_i;
         3'd1:    op_res = a_i | b_i;
         3'd2:    op_res = a_i ^ b_i;
         3'd3:    op_res = ~(a_i & b_i);
         3'd4:    op_res = ~(a_i | b_i);
         3'd5:    op_res = ~(a_i ^ b_i);
         3'd6:    op_res = a_i & ~b_i;
         default: op_res = a_i;
      endcase
   end

`ifdef LOGIC_UNIT_STATUS_EN
   assign in_pay = {~|op_res, ^op_res, op_res};
`else
   assign in_pay = op_res;
`endif

   // ready[k] = !valid[k] || ready[k+1] unrolled: a stage can load if the downstream
   // consumer is ready or any stage from k to the output end holds a bubble.
   for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_rdy
      assign stage_rdy[k] = out_ready_i | ~(&stage_vld[PIPE_STAGES-1:k]);
   end

   // Stage registers: valid follows its source on load, data only updates with a valid source.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         stage_vld <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) begin
            stage_dat[k] <= '0;
         end
      end else begin
         if (stage_rdy[0]) begin
            stage_vld[0] <= in_valid_i;
            if (in_valid_i) begin
               stage_dat[0] <= in_pay;
            end
         end
         for (int k = 1; k < PIPE_STAGES; k++) begin
            if (stage_rdy[k]) begin
               stage_vld[k] <= stage_vld[k-1];
               if (stage_vld[k-1]) begin
                  stage_dat[k] <= stage_dat[k-1];
               end
            end
         end
      end
   end

   assign in_ready_o  = stage_rdy[0];
   assign out_valid_o = stage_vld[PIPE_STAGES-1];
   assign result_o    = stage_dat[PIPE_STAGES-1][DATA_WIDTH-1:0];

`ifdef LOGIC_UNIT_STATUS_EN
   assign zero_o   = stage_dat[PIPE_STAGES-1][DATA_WIDTH+1];
   assign parity_o = stage_dat[PIPE_STAGES-1][DATA_WIDTH];
`else
   assign zero_o   = 1'b0;
   assign parity_o = 1'b0;
`endif

endmodule
